shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 28 ++
 rtl/shift_sequencer_if.sv | 26 ++
 rtl/shift_sequencer_stage.sv | 32 +++
 rtl/shift_sequencer.sv | 94 +++++++++
 tb/tb_shift_sequencer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared encodings and constants for the shift sequencer
package shift_sequencer_pkg;

    localparam int DATA_W     = 32;
    localparam int SHAMT_W    = 5;
    localparam int NUM_STAGES = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Stage k shifts by 16 >> k, so the MSB of shamt is consumed first.
    function automatic logic [SHAMT_W-1:0] stage_amount(input logic [2:0] k);
        logic [SHAMT_W-1:0] base;
        base = 5'd16;
        return base >> k;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/response bundle of the shift sequencer
interface shift_sequencer_if;
    import shift_sequencer_pkg::*;

    logic               start;
    logic [1:0]         op;
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    logic               flush;
    logic               ready;
    logic               busy;
    logic               done;
    logic               illegal_op;
    logic [DATA_W-1:0]  result;

    modport master (
        output start, op, data, shamt, flush,
        input  ready, busy, done, illegal_op, result
    );

    modport slave (
        input  start, op, data, shamt, flush,
        output ready, busy, done, illegal_op, result
    );

endinterface

// File: rtl/shift_sequencer_stage.sv
// rtl/shift_sequencer_stage.sv - one combinational shift stage with selectable fill
module shift_stage
    import shift_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0]  word,
    input  logic [SHAMT_W-1:0] amount,
    input  logic               direction,
    input  logic               fill,
    input  logic               enable,
    output logic [DATA_W-1:0]  shifted
);

    logic [DATA_W-1:0] ones;
    logic [DATA_W-1:0] fill_mask;
    logic [DATA_W-1:0] moved;

    // direction: 0 = left, 1 = right; vacated positions take the fill bit.
    always_comb begin
        ones      = '1;
        fill_mask = '0;
        moved     = word;
        if (direction) begin
            moved     = word >> amount;
            fill_mask = ~(ones >> amount);
        end else begin
            moved     = word << amount;
            fill_mask = ~(ones << amount);
        end
        shifted = enable ? (moved | (fill ? fill_mask : '0)) : word;
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - five-stage iterative barrel shifter with fixed latency
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    shift_sequencer_if.slave bus
);

    localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

    state_e             state;
    state_e             state_nxt;
    logic [2:0]         stage;
    logic [DATA_W-1:0]  work;
    logic [DATA_W-1:0]  work_nxt;
    logic [DATA_W-1:0]  result_q;
    logic [SHAMT_W-1:0] shamt_q;
    op_e                op_q;
    logic               fill_q;
    logic               accept;
    logic               done_int;
    logic               stage_en;

    assign accept   = (state == ST_IDLE) && bus.start && !bus.flush;
    assign stage_en = shamt_q[3'd4 - stage] && (op_q != OP_ILL);

    shift_stage u_stage (
        .word      (work),
        .amount    (stage_amount(stage)),
        .direction (op_q != OP_SLL),
        .fill      (fill_q && (op_q == OP_SRA)),
        .enable    (stage_en),
        .shifted   (work_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            stage    <= '0;
            work     <= '0;
            result_q <= '0;
            shamt_q  <= '0;
            op_q     <= OP_SLL;
            fill_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        work    <= bus.data;
                        shamt_q <= bus.shamt;
                        op_q    <= op_e'(bus.op);
                        fill_q  <= bus.data[DATA_W-1];
                        stage   <= '0;
                    end
                end
                ST_SHIFT: begin
                    work  <= work_nxt;
                    stage <= stage + 3'd1;
                end
                ST_DONE: begin
                    if (!bus.flush) result_q <= work;
                    stage <= '0;
                end
                default: stage <= '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (bus.flush)                state_nxt = ST_IDLE;
                else if (stage == LAST_STAGE) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A flush or reset landing in the DONE cycle hides the pulse and keeps the old result visible.
    always_comb begin
        done_int       = (state == ST_DONE) && !bus.flush && !reset;
        bus.ready      = (state == ST_IDLE);
        bus.busy       = (state != ST_IDLE);
        bus.done       = done_int;
        bus.illegal_op = done_int && (op_q == OP_ILL);
        bus.result     = done_int ? work : result_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for the shift sequencer
module tb_shift_sequencer;

    typedef struct {
        logic [31:0] result;
        logic        illegal;
        int          due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];
    logic [31:0] last_result;

    shift_sequencer_if bus ();

    shift_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $unsigned($signed(d) >>> s);
            default: return d;
        endcase
    endfunction

    // Done is due in the DONE cycle, sampled six negedges after the start was set up.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",     bus.result,     e.result);
                chk("illegal_op", {31'd0, bus.illegal_op}, {31'd0, e.illegal});
                chk("latency",    cyc,            e.due);
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            chk("done_seen", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
    end

    // Called while IDLE; returns at the negedge of the DONE cycle.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                          input bit poke_starts);
        exp_t e;
        @(negedge clk);
        bus.data  = d;
        bus.shamt = s;
        bus.op    = op;
        bus.start = 1'b1;
        e.result  = model(d, s, op);
        e.illegal = (op == 2'b11);
        e.due     = cyc + 6;
        sb.push_back(e);
        last_result = e.result;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus.start = poke_starts && (i == 2 || i == 4);
            bus.data  = $urandom;
            bus.shamt = 5'($urandom);
            bus.op    = 2'($urandom);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        last_result = '0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.data  = '0;
        bus.shamt = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  {31'd0, bus.ready},      32'd1);
        chk("rst_busy",   {31'd0, bus.busy},       32'd0);
        chk("rst_done",   {31'd0, bus.done},       32'd0);
        chk("rst_ill",    {31'd0, bus.illegal_op}, 32'd0);
        chk("rst_result", bus.result,              32'd0);
        reset = 1'b0;

        run_op(32'h8000_0000, 5'd31, 2'b01, 1'b0);
        run_op(32'hF000_0000, 5'd16, 2'b10, 1'b0);
        run_op(32'hF000_0000, 5'd0,  2'b10, 1'b0);
        run_op(32'h0000_00FF, 5'd12, 2'b00, 1'b1);
        run_op(32'h1234_5678, 5'd5,  2'b11, 1'b0);

        // start raised in the DONE cycle must not be accepted
        run_op(32'hA5A5_0001, 5'd1, 2'b00, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_start_ignored_busy",  {31'd0, bus.busy},  32'd0);
        chk("done_start_ignored_ready", {31'd0, bus.ready}, 32'd1);
        chk("result_hold",              bus.result,         last_result);

        for (int i = 0; i < 16; i++) begin
            run_op($urandom, 5'($urandom), 2'($urandom), 1'b0);
            @(negedge clk);
        end
        run_op(32'h8000_0001, 5'd31, 2'b00, 1'b0);
        run_op(32'h8000_0001, 5'd1,  2'b10, 1'b0);

        // flush and start together in IDLE
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start_busy", {31'd0, bus.busy}, 32'd0);

        // flush in SHIFT cycle 2
        @(negedge clk);
        bus.data  = 32'hFFFF_FFFF;
        bus.shamt = 5'd4;
        bus.op    = 2'b01;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("shift_busy", {31'd0, bus.busy}, 32'd1);
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_ready",  {31'd0, bus.ready}, 32'd1);
        chk("flush_result", bus.result,         last_result);
        repeat (8) @(negedge clk);

        // reset mid-SHIFT
        bus.data  = 32'h0F0F_0F0F;
        bus.shamt = 5'd3;
        bus.op    = 2'b00;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_result", bus.result,         32'd0);
        chk("midrst_ready",  {31'd0, bus.ready}, 32'd1);
        chk("midrst_busy",   {31'd0, bus.busy},  32'd0);
        repeat (10) @(negedge clk);

        chk("pending_done", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
